// File: rtl/unified_mem_arbiter.sv
// Arbiter that lets IF and MEM share one single-ported, fixed-latency memory.
// Data accesses win; a starvation counter forces a fetch after STARVE_LIMIT data grants in a row.
//
// state | meaning
// IDLE  | evaluate requests, grant D or I
// ISSUE | mem_en strobe for the granted access
// WAIT  | memory latency, MEM_LATENCY cycles
// RESP  | ack to the granted port, requests ignored
module unified_mem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LATENCY  = 2,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              busy
);

   localparam int WCW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int SCW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state;
   logic             gnt_d;
   logic             we_q;
   logic [WCW-1:0]   wait_cnt;
   logic [SCW-1:0]   starve_cnt;
   logic             grant_d;
   logic             unused_addr_lsbs;

   assign grant_d   = d_req & (~i_req | (starve_cnt < SCW'(STARVE_LIMIT)));
   assign stall_if  = i_req & ~i_ack;
   assign stall_mem = d_req & ~d_ack;

   // Byte-offset bits carry no meaning for a word-wide memory.
   assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         gnt_d      <= 1'b0;
         we_q       <= 1'b0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_ack      <= 1'b0;
         d_ack      <= 1'b0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         busy       <= 1'b0;
      end else begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d || i_req) begin
                  gnt_d     <= grant_d;
                  we_q      <= grant_d & d_we;
                  mem_en    <= 1'b1;
                  mem_we    <= grant_d & d_we;
                  mem_addr  <= grant_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                  mem_wdata <= grant_d ? d_wdata : '0;
                  busy      <= 1'b1;
                  state     <= ISSUE;
                  if (grant_d && i_req) begin
                     if (starve_cnt != SCW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                  end else begin
                     starve_cnt <= '0;
                  end
               end
            end
            ISSUE: begin
               wait_cnt <= WCW'(MEM_LATENCY - 1);
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  // mem_rdata is valid in the last WAIT cycle; stores leave d_rdata alone.
                  if (gnt_d) begin
                     if (!we_q)
                        d_rdata <= mem_rdata;
                     d_ack <= 1'b1;
                  end else begin
                     i_rdata <= mem_rdata;
                     i_ack   <= 1'b1;
                  end
                  state <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter that shares one single-ported, fixed-latency unified memory between the instruction-fetch (IF) port and the data (MEM) port of the five-stage MIPS-32 pipeline. It serializes accesses and returns read data with a one-cycle acknowledge pulse. It generates the stall signals the pipeline uses to freeze IF or MEM while an access is pending. Data accesses have priority, and a starvation counter guarantees forward progress of instruction fetch.

## Interface
- ADDR_W, 32, byte-address width of both requester ports
- DATA_W, 32, word width
- MEM_LATENCY, 2, cycles from the mem_en cycle until mem_rdata is valid (≥1)
- STARVE_LIMIT, 3, maximum consecutive data grants while i_req is pending (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- i_req  in  1  instruction fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch byte address, word-aligned
- i_rdata  out  DATA_W  fetched word, valid when i_ack=1
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address, word-aligned
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ack=1
- d_ack  out  1  one-cycle completion pulse
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W-2  word address, equal to the granted addr[ADDR_W-1:2]
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid MEM_LATENCY cycles after the mem_en cycle
- stall_if  out  1  i_req & ~i_ack (combinational)
- stall_mem  out  1  d_req & ~d_ack (combinational)
- busy  out  1  FSM not in IDLE

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - ISSUE: mem_en=1 for exactly one cycle.
  - WAIT: lasts MEM_LATENCY cycles.
  - RESP: the granted port's ack=1; then return to IDLE.
- Grant rule in IDLE:
  - if d_req and (~i_req or starve_cnt < STARVE_LIMIT): grant D.
  - else if i_req: grant I.
  - else stay in IDLE.
- At grant, latch port id, word address, we (0 for I), and wdata. Requester inputs are not sampled again until RESP.
- starve_cnt:
  - increments on a D grant while i_req=1;
  - clears on an I grant, or on a D grant while i_req=0;
  - saturates at STARVE_LIMIT.
- Read data: mem_rdata is registered at the last WAIT edge into the granted port's rdata, which holds until the next read completes on that port.
- Stores also receive d_ack at the same timing; d_rdata is unchanged by a store.
- Requests are ignored during the RESP cycle. A requester holding req high after its ack is treated as a new request in the following IDLE cycle.
- Address bits [1:0] are discarded; misalignment is not flagged.

## Timing
- Reset (rst=0 at a clock edge): state goes to IDLE and starve_cnt to 0. mem_en, mem_we, i_ack, d_ack, and busy are 0. mem_addr, mem_wdata, i_rdata, and d_rdata are 0.
- Reset mid-access abandons the access: no ack is issued, and a store already strobed is not undone.
- With the request seen in IDLE at cycle C0:
  - mem_en=1 in C0+1;
  - WAIT occupies C0+2 through C0+1+MEM_LATENCY;
  - ack=1 in C0+2+MEM_LATENCY;
  - IDLE resumes in C0+3+MEM_LATENCY.
- Latency from request to ack is MEM_LATENCY+2 cycles; back-to-back accesses start every MEM_LATENCY+3 cycles.
- mem_we, mem_addr, and mem_wdata are driven in the ISSUE cycle and are 0 otherwise.
- stall_if and stall_mem deassert in the ack cycle, so the pipeline advances on that edge.
- Simultaneous i_req and d_req with starve_cnt=0: D is granted first, and I is granted in the IDLE cycle after D's RESP.
- Only one ack is high in any cycle; an ack is never asserted in a cycle when busy=0.

## Test plan
- Reset: hold rst=0 for 2 cycles with both requests high → all outputs 0, no mem_en; release → D is granted in the first IDLE cycle.
- Single fetch (MEM_LATENCY=2): i_req with i_addr=0x10 at C0, memory returns 0x8FE00000 → mem_en=1 with mem_addr=4 in C1 only; i_ack=1 and i_rdata=0x8FE00000 in C4; stall_if=1 in C0–C3.
- Store then load: d_we=1, d_addr=0x0, d_wdata=3 → mem_we=1, mem_wdata=3, d_ack in C4. Then a load from 0x0 → d_rdata=3 and d_rdata unchanged by the store.
- Contention: i_req and d_req both rise at C0 → D's mem_en in C1, d_ack in C4, I's mem_en in C6, i_ack in C9.
- Starvation (STARVE_LIMIT=3): d_req and i_req held continuously with acks consumed → grant order D,D,D,I,D,D,D,I; stall_if never exceeds 4 accesses.
- Reset mid-WAIT: assert rst=0 in C2 of a fetch → no i_ack; busy=0 the next cycle; a new fetch after release completes normally.
